// File: rtl/intel_hex_tx.sv
// intel_hex_tx - binary-to-Intel-HEX encoder.
//
// Reads LEN bytes starting at BASE from a synchronous RAM (1-cycle read
// latency). It sends them as ASCII Intel HEX data records of at most
// REC_MAX bytes each, then sends the end-of-file record ':00000001FF'.
// Records never cross the 0xFFFF -> 0x0000 address wrap.
//
// Build option: define INTEL_HEX_CRLF_EN to terminate every record
// (including EOF) with CR LF. When it is undefined, records are sent
// back-to-back and the CR/LF states do not exist.
//
// Ports:
//   CLK    in   system clock, rising edge
//   CLR    in   synchronous active-high reset
//   START  in   one-cycle pulse, starts a dump when idle
//   BASE   in   [15:0] first memory address, sampled on START
//   LEN    in   [16:0] byte count (0..65536), sampled on START
//   AB     out  [15:0] memory address (valid while RE=1)
//   RE     out  memory read strobe, DI valid the following cycle
//   DI     in   [7:0] memory read data
//   DO     out  [7:0] ASCII character
//   VLD    out  DO valid
//   RDY    in   sink ready, character moves on VLD & RDY
//   BUSY   out  dump in progress
//   DONE   out  one-cycle pulse after the last character is accepted
module intel_hex_tx #(
  parameter int REC_MAX = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        START,
  input  logic [15:0] BASE,
  input  logic [16:0] LEN,
  output logic [15:0] AB,
  output logic        RE,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        VLD,
  input  logic        RDY,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [16:0] REC_MAX_W = 17'(REC_MAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOC,
    S_HDR,
    S_FETCH,
    S_CAPT,
    S_DATA,
    S_CHK,
`ifdef INTEL_HEX_CRLF_EN
    S_CR,
    S_LF,
`endif
    S_EOF,
    S_FIN
  } state_t;

  state_t state, state_nx;

  // Control
  logic [3:0]  nib;        // character index within the current field
`ifdef INTEL_HEX_CRLF_EN
  logic        eof_done;   // EOF record already sent, CR/LF leads to FIN
`endif

  // Datapath (no reset, always loaded before use)
  logic [15:0] addr;       // next memory address to read
  logic [16:0] rem;        // bytes still to dump
  logic [7:0]  cnt;        // bytes left in the current record
  logic [7:0]  ll;         // current record length
  logic [15:0] rec_addr;   // current record start address
  logic [7:0]  sum;        // running checksum sum
  logic [7:0]  dbyte;      // captured data byte

  logic [16:0] to_wrap;
  logic [16:0] lmin;
  logic [7:0]  ll_next;
  logic [7:0]  hdr_byte;
  logic [7:0]  chk;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [3:0] sel_nib(input logic [7:0] b, input logic lo);
    return lo ? b[3:0] : b[7:4];
  endfunction

  // ':00000001FF', index 0..10
  function automatic logic [7:0] eof_char(input logic [3:0] i);
    case (i)
      4'd0:         return 8'h3A;
      4'd8:         return 8'h31;
      4'd9, 4'd10:  return 8'h46;
      default:      return 8'h30;
    endcase
  endfunction

  // Record length: limited by remaining bytes, REC_MAX and the 64K wrap.
  always_comb begin
    to_wrap = 17'h10000 - {1'b0, addr};
    lmin    = rem;
    if (to_wrap < lmin)   lmin = to_wrap;
    if (REC_MAX_W < lmin) lmin = REC_MAX_W;
    ll_next = lmin[7:0];
  end

  always_comb begin
    case (nib[2:1])
      2'd0:    hdr_byte = ll;
      2'd1:    hdr_byte = rec_addr[15:8];
      2'd2:    hdr_byte = rec_addr[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  assign chk = ~sum + 8'd1;

  always_ff @(posedge CLK) begin
    if (CLR) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    DO       = 8'h00;
    VLD      = 1'b0;
    RE       = 1'b0;
    AB       = 16'h0000;
    DONE     = 1'b0;
    BUSY     = (state != S_IDLE) && (state != S_FIN);
    case (state)
      S_IDLE: begin
        if (START) state_nx = (LEN == 17'd0) ? S_EOF : S_SOC;
      end
      S_SOC: begin
        DO  = 8'h3A;
        VLD = 1'b1;
        if (RDY) state_nx = S_HDR;
      end
      S_HDR: begin
        DO  = hex_char(sel_nib(hdr_byte, nib[0]));
        VLD = 1'b1;
        if (RDY && nib == 4'd7) state_nx = S_FETCH;
      end
      S_FETCH: begin
        RE       = 1'b1;
        AB       = addr;
        state_nx = S_CAPT;
      end
      S_CAPT: begin
        state_nx = S_DATA;
      end
      S_DATA: begin
        DO  = hex_char(sel_nib(dbyte, nib[0]));
        VLD = 1'b1;
        if (RDY && nib == 4'd1) state_nx = (cnt != 8'd0) ? S_FETCH : S_CHK;
      end
      S_CHK: begin
        DO  = hex_char(sel_nib(chk, nib[0]));
        VLD = 1'b1;
        if (RDY && nib == 4'd1) begin
`ifdef INTEL_HEX_CRLF_EN
          state_nx = S_CR;
`else
          state_nx = (rem != 17'd0) ? S_SOC : S_EOF;
`endif
        end
      end
`ifdef INTEL_HEX_CRLF_EN
      S_CR: begin
        DO  = 8'h0D;
        VLD = 1'b1;
        if (RDY) state_nx = S_LF;
      end
      S_LF: begin
        DO  = 8'h0A;
        VLD = 1'b1;
        if (RDY) begin
          if (eof_done)            state_nx = S_FIN;
          else if (rem != 17'd0)   state_nx = S_SOC;
          else                     state_nx = S_EOF;
        end
      end
`endif
      S_EOF: begin
        DO  = eof_char(nib);
        VLD = 1'b1;
        if (RDY && nib == 4'd10) begin
`ifdef INTEL_HEX_CRLF_EN
          state_nx = S_CR;
`else
          state_nx = S_FIN;
`endif
        end
      end
      S_FIN: begin
        DONE     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Character index restarts on every state change.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      nib <= 4'd0;
    end else if (state_nx != state) begin
      nib <= 4'd0;
    end else if (VLD && RDY) begin
      nib <= nib + 4'd1;
    end
  end

`ifdef INTEL_HEX_CRLF_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      eof_done <= 1'b0;
    end else if (state == S_IDLE) begin
      eof_done <= 1'b0;
    end else if (state == S_EOF && RDY && nib == 4'd10) begin
      eof_done <= 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    case (state)
      S_IDLE: begin
        if (START) begin
          addr <= BASE;
          rem  <= LEN;
        end
      end
      S_SOC: begin
        if (RDY) begin
          ll       <= ll_next;
          cnt      <= ll_next;
          rec_addr <= addr;
          sum      <= ll_next + addr[15:8] + addr[7:0];
        end
      end
      S_CAPT: begin
        dbyte <= DI;
        sum   <= sum + DI;
        addr  <= addr + 16'd1;
        rem   <= rem - 17'd1;
        cnt   <= cnt - 8'd1;
      end
      default: ;
    endcase
  end

endmodule
